// File: rtl/regfile_scoreboard_if.sv
// Dump-port bundle of regfile_scoreboard: start/ready come from the debug consumer,
// beat data and status go back to it.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_active;
    logic              dump_done;

    modport master (
        output dump_start, dump_ready,
        input  dump_valid, dump_addr, dump_data, dump_active, dump_done
    );

    modport slave (
        input  dump_start, dump_ready,
        output dump_valid, dump_addr, dump_data, dump_active, dump_done
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with byte-lane writes, optional r0 hardwiring and write bypass,
// a per-register busy scoreboard and a handshaked sequential dump port.
module regfile_scoreboard #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                LED_REG  = 25,
    parameter logic [DATA_W-1:0] LED_INIT = {DATA_W{1'b1}},
    parameter bit                R0_ZERO  = 1'b0,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W/8-1:0] write_strb,
    input  logic [ADDR_W-1:0] read_reg_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic [DATA_W-1:0] led_output,
    regfile_scoreboard_if.slave dump
);
    localparam int                DEPTH   = 2 ** ADDR_W;
    localparam int                STRB_W  = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LED_IDX = ADDR_W'(LED_REG);

    typedef enum logic [1:0] {IDLE, LOAD, PRESENT, DONE} dump_state_t;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_en;
    logic              iss_en;

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic              d_valid, d_active, d_done;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data;

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int k = 0; k < STRB_W; k++)
            if (strb[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] r0_mask(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] v);
        return (R0_ZERO && a == '0) ? '0 : v;
    endfunction

    assign wr_en     = reg_write && !(R0_ZERO && write_register == '0);
    assign iss_en    = issue_valid && !(R0_ZERO && issue_reg == '0);
    assign wr_merged = byte_merge(rf[write_register], write_data, write_strb);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                rf[ADDR_W'(i)] <= (i == LED_REG) ? LED_INIT : '0;
        end else if (wr_en) begin
            rf[write_register] <= wr_merged;
        end
    end

    // Issue is applied after the write-clear so a same-cycle issue leaves the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (reg_write) busy[write_register] <= 1'b0;
            if (iss_en)    busy[issue_reg]      <= 1'b1;
        end
    end

    always_comb begin
        read_data_1 = rf[read_reg_1];
        read_data_2 = rf[read_reg_2];
        if (BYPASS && reg_write && write_register == read_reg_1) read_data_1 = wr_merged;
        if (BYPASS && reg_write && write_register == read_reg_2) read_data_2 = wr_merged;
        read_data_1 = r0_mask(read_reg_1, read_data_1);
        read_data_2 = r0_mask(read_reg_2, read_data_2);
    end

    assign busy_1     = busy[read_reg_1];
    assign busy_2     = busy[read_reg_2];
    assign led_output = rf[LED_IDX];

    // Outputs are registered alongside the state transition so they track the state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            d_valid  <= 1'b0;
            d_active <= 1'b0;
            d_done   <= 1'b0;
            d_addr   <= '0;
            d_data   <= '0;
        end else begin
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dump.dump_start) begin
                        state    <= LOAD;
                        idx      <= '0;
                        d_active <= 1'b1;
                    end
                end
                LOAD: begin
                    d_data  <= r0_mask(idx, rf[idx]);
                    d_addr  <= idx;
                    d_valid <= 1'b1;
                    state   <= PRESENT;
                end
                PRESENT: begin
                    if (dump.dump_ready) begin
                        d_valid <= 1'b0;
                        if (idx == '1) begin
                            state  <= DONE;
                            d_done <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    d_active <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dump.dump_valid  = d_valid;
    assign dump.dump_active = d_active;
    assign dump.dump_done   = d_done;
    assign dump.dump_addr   = d_addr;
    assign dump.dump_data   = d_data;
endmodule
